// File: rtl/led_pixel_fetcher.sv
// ---------------------------------------------------------------------------
// led_pixel_fetcher
//
// Read-side client of the frame-buffer bus arbiter. A start pulse makes the
// block walk NUM_PIXELS pixels of BYTES_PER_PIXEL bytes each, starting at
// base_addr. It uses a four-phase req/rdy handshake toward the arbiter. The
// bytes of each pixel are packed into one word, with the first fetched byte
// in the MSBs. Each word is then offered to the LED serializer on a
// valid/ready stream. A one-word output register lets the fetch of pixel n+1
// run while the serializer still holds pixel n.
//
// Optional feature (macro LED_PIXEL_FETCHER_BRIGHTNESS_EN):
//   When defined, every captured byte b is stored as (b*brightness)>>8.
//   When undefined, bytes are stored as read and brightness is ignored.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse, begins a frame when idle
//   base_addr   frame start address, sampled when start is accepted
//   busy        high from accepted start until the last pixel is accepted
//   frame_done  one-cycle pulse when the last pixel is accepted
//   data_req    request to the arbiter channel
//   data_addr   request address, stable while data_req is high
//   data_in     read data from the arbiter, valid while data_rdy is high
//   data_rdy    arbiter ready/acknowledge
//   brightness  global scale (only used with the optional feature)
//   pix_data    packed pixel word
//   pix_valid   pix_data valid
//   pix_ready   serializer accepts when pix_valid & pix_ready
//   pix_last    high with the final pixel of the frame
// ---------------------------------------------------------------------------
module led_pixel_fetcher #(
   parameter int ADDRESS_WIDTH   = 8,
   parameter int DATA_WIDTH      = 8,
   parameter int NUM_PIXELS      = 16,
   parameter int BYTES_PER_PIXEL = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [ADDRESS_WIDTH-1:0]              base_addr,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic                                  data_req,
   output logic [ADDRESS_WIDTH-1:0]              data_addr,
   input  logic [DATA_WIDTH-1:0]                 data_in,
   input  logic                                  data_rdy,
   input  logic [7:0]                            brightness,
   output logic [DATA_WIDTH*BYTES_PER_PIXEL-1:0] pix_data,
   output logic                                  pix_valid,
   input  logic                                  pix_ready,
   output logic                                  pix_last
);

   localparam int WORD_WIDTH = DATA_WIDTH * BYTES_PER_PIXEL;
   localparam int PIX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int BYTE_W     = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIXELS - 1);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_PIXEL - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      REL,
      PUSH
   } state_t;

   state_t                  state;
   logic [PIX_W-1:0]        pixel_idx;
   logic [BYTE_W-1:0]       byte_idx;
   logic [WORD_WIDTH-1:0]   assembly;
   logic [DATA_WIDTH-1:0]   captured;

`ifdef LED_PIXEL_FETCHER_BRIGHTNESS_EN
   // Brightness scaling sits between data_in and the assembly register.
   // It is purely combinational, so a scaled byte is captured on the same
   // edge as an unscaled one would be.
   logic [DATA_WIDTH+7:0] scaled;
   assign scaled   = {8'd0, data_in} * {{DATA_WIDTH{1'b0}}, brightness};
   assign captured = scaled[DATA_WIDTH+7:8];
`else
   // Without scaling, bytes pass straight through. brightness is still a
   // port so both builds share one pin-out.
   logic unused_brightness;
   assign unused_brightness = ^brightness;
   assign captured          = data_in;
`endif

   // Fetch FSM plus output register.
   // Addresses advance with a running counter. Fetches are strictly
   // sequential, so data_addr + 1 always equals
   // base + pixel*BYTES_PER_PIXEL + byte, wrapping naturally at the bus width.
   // The output register is cleared first in each cycle where it is
   // accepted. A PUSH load later in the same block overrides that clear,
   // which lets pixels go out back to back with no bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pixel_idx  <= '0;
         byte_idx   <= '0;
         assembly   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         data_req   <= 1'b0;
         data_addr  <= '0;
         pix_data   <= '0;
         pix_valid  <= 1'b0;
         pix_last   <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (pix_last) begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (start && !busy) begin
                  busy      <= 1'b1;
                  pixel_idx <= '0;
                  byte_idx  <= '0;
                  assembly  <= '0;
                  data_addr <= base_addr;
                  data_req  <= 1'b1;
                  state     <= REQ;
               end
            end

            REQ: begin
               if (data_rdy) begin
                  for (int i = 0; i < BYTES_PER_PIXEL; i++) begin
                     if (byte_idx == BYTE_W'(i)) begin
                        assembly[(BYTES_PER_PIXEL-1-i)*DATA_WIDTH +: DATA_WIDTH] <= captured;
                     end
                  end
                  data_req <= 1'b0;
                  state    <= REL;
               end
            end

            REL: begin
               if (!data_rdy) begin
                  if (byte_idx != LAST_BYTE) begin
                     byte_idx  <= byte_idx + BYTE_W'(1);
                     data_addr <= data_addr + ADDRESS_WIDTH'(1);
                     data_req  <= 1'b1;
                     state     <= REQ;
                  end else begin
                     state <= PUSH;
                  end
               end
            end

            PUSH: begin
               if (!pix_valid || pix_ready) begin
                  pix_data  <= assembly;
                  pix_valid <= 1'b1;
                  pix_last  <= (pixel_idx == LAST_PIX);
                  if (pixel_idx == LAST_PIX) begin
                     state <= IDLE;
                  end else begin
                     pixel_idx <= pixel_idx + PIX_W'(1);
                     byte_idx  <= '0;
                     data_addr <= data_addr + ADDRESS_WIDTH'(1);
                     data_req  <= 1'b1;
                     state     <= REQ;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_led_pixel_fetcher.sv
// ---------------------------------------------------------------------------
// tb_led_pixel_fetcher
//
// Directed bench for led_pixel_fetcher with NUM_PIXELS=2, BYTES_PER_PIXEL=3.
// Memory model: mem[a] = a - 0x0F, so 0x10..0x15 hold 01..06.
// The arbiter model is registered. It raises data_rdy one cycle after it
// sees data_req, and can add extra wait cycles for one chosen address.
// ---------------------------------------------------------------------------
module tb_led_pixel_fetcher;

   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int NP  = 2;
   localparam int BPP = 3;
   localparam int WW  = DW * BPP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic          busy;
   logic          frame_done;
   logic          data_req;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_in = '0;
   logic          data_rdy = 1'b0;
   logic [7:0]    brightness = 8'hFF;
   logic [WW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready = 1'b1;
   logic          pix_last;

   int checks = 0;
   int failures = 0;

   // Arbiter stall control, set from the stimulus process only
   int            stall_len = 0;
   logic [AW-1:0] stall_addr = 8'h11;

   always #5 clk = ~clk;

   led_pixel_fetcher #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .NUM_PIXELS(NP),
      .BYTES_PER_PIXEL(BPP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .busy(busy),
      .frame_done(frame_done),
      .data_req(data_req),
      .data_addr(data_addr),
      .data_in(data_in),
      .data_rdy(data_rdy),
      .brightness(brightness),
      .pix_data(pix_data),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .pix_last(pix_last)
   );

   function automatic logic [7:0] mem_byte(input logic [7:0] a);
      return a - 8'h0F;
   endfunction

   // Expected word for the general tests, which run at brightness 255
   function automatic logic [WW-1:0] exp_pix(input logic [WW-1:0] w);
`ifdef LED_PIXEL_FETCHER_BRIGHTNESS_EN
      logic [WW-1:0] r;
      logic [15:0]   p;
      for (int i = 0; i < BPP; i++) begin
         p = {8'd0, w[i*8 +: 8]} * 16'd255;
         r[i*8 +: 8] = p[15:8];
      end
      return r;
`else
      return w;
`endif
   endfunction

   // Four-phase arbiter model: grant after an optional stall, then hold rdy
   // high until the request drops, then drop rdy.
   int wait_cnt = 0;
   always @(posedge clk) begin
      if (rst) begin
         data_rdy <= 1'b0;
         wait_cnt <= 0;
      end else if (data_req && !data_rdy) begin
         if (data_addr == stall_addr && wait_cnt < stall_len) begin
            wait_cnt <= wait_cnt + 1;
         end else begin
            data_rdy <= 1'b1;
            data_in  <= mem_byte(data_addr);
            wait_cnt <= 0;
         end
      end else if (!data_req) begin
         data_rdy <= 1'b0;
      end
   end

   // Passive monitors. They log request addresses, accepted pixels,
   // frame_done pulses, address changes during a request, and how many
   // cycles the stalled address stays requested.
   logic [AW-1:0] addr_log[$];
   logic [WW-1:0] pix_log[$];
   logic          last_log[$];
   int            done_count = 0;
   int            addr_glitch = 0;
   int            stall_hi_cycles = 0;
   logic          req_prev = 1'b0;
   logic [AW-1:0] addr_prev = '0;
   always @(posedge clk) begin
      if (data_req && !req_prev) addr_log.push_back(data_addr);
      if (data_req && req_prev && data_addr !== addr_prev) addr_glitch++;
      if (data_req && data_addr == stall_addr && stall_len > 0) stall_hi_cycles++;
      if (pix_valid && pix_ready) begin
         pix_log.push_back(pix_data);
         last_log.push_back(pix_last);
      end
      if (frame_done) done_count++;
      req_prev  <= data_req;
      addr_prev <= data_addr;
   end

   // Start a frame and wait, within a bounded number of cycles, for its
   // frame_done pulse. If extra_at >= 0, a second start (base 0x80) is
   // pulsed that many cycles in. Returns at the negedge where frame_done is
   // high, with log snapshots taken before the frame began.
   task automatic run_frame(input logic [AW-1:0] b, input int extra_at,
                            output int a0, output int p0, output int f0);
      logic done;
      a0 = addr_log.size();
      p0 = pix_log.size();
      f0 = done_count;
      done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      for (int i = 0; i < 600 && !done; i++) begin
         @(negedge clk);
         if (i == extra_at) begin
            start = 1'b1;
            base_addr = 8'h80;
         end else begin
            start = 1'b0;
         end
         if (frame_done) done = 1'b1;
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_timeout base=%h: got done=%b, expected 1", b, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, frame_done, data_req, pix_valid, pix_last, data_addr, pix_data} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b req=%b valid=%b last=%b addr=%h data=%h, expected all 0",
                  busy, frame_done, data_req, pix_valid, pix_last, data_addr, pix_data);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      int a0, p0, f0;
      logic [AW-1:0] exp_addr [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      pix_ready = 1'b1;
      run_frame(8'h10, -1, a0, p0, f0);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_busy_with_done: got %b, expected 0", busy);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL basic_done_pulse_width: got %b, expected 0", frame_done);
      end
      checks++;
      if (done_count - f0 !== 1) begin
         failures++;
         $display("[TB] FAIL basic_done_count: got %0d, expected 1", done_count - f0);
      end
      checks++;
      if (pix_log.size() - p0 !== 2) begin
         failures++;
         $display("[TB] FAIL basic_pix_count: got %0d, expected 2", pix_log.size() - p0);
      end
      checks++;
      if (pix_log[p0] !== exp_pix(24'h010203)) begin
         failures++;
         $display("[TB] FAIL basic_pix0: got %h, expected %h", pix_log[p0], exp_pix(24'h010203));
      end
      checks++;
      if (pix_log[p0+1] !== exp_pix(24'h040506)) begin
         failures++;
         $display("[TB] FAIL basic_pix1: got %h, expected %h", pix_log[p0+1], exp_pix(24'h040506));
      end
      checks++;
      if ({last_log[p0], last_log[p0+1]} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL basic_pix_last: got %b%b, expected 01", last_log[p0], last_log[p0+1]);
      end
      checks++;
      if (addr_log.size() - a0 !== 6) begin
         failures++;
         $display("[TB] FAIL basic_req_count: got %0d, expected 6", addr_log.size() - a0);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (addr_log[a0+i] !== exp_addr[i]) begin
            failures++;
            $display("[TB] FAIL basic_addr[%0d]: got %h, expected %h", i, addr_log[a0+i], exp_addr[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int a0;
      logic seen, unstable;
      a0 = addr_log.size();
      seen = 1'b0;
      unstable = 1'b0;
      pix_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      base_addr = 8'h20;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pix_valid) begin
            seen = 1'b1;
            if (pix_data !== exp_pix(24'h111213)) unstable = 1'b1;
         end
      end
      checks++;
      if ({seen, unstable} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL bp_pix0_held: got seen=%b unstable=%b, expected seen=1 unstable=0", seen, unstable);
      end
      checks++;
      if ({pix_valid, pix_last, data_req, busy} !== 4'b1001) begin
         failures++;
         $display("[TB] FAIL bp_waiting_state: got valid,last,req,busy=%b%b%b%b, expected 1001",
                  pix_valid, pix_last, data_req, busy);
      end
      checks++;
      if (addr_log.size() - a0 !== 6) begin
         failures++;
         $display("[TB] FAIL bp_pix1_prefetched: got %0d requests, expected 6", addr_log.size() - a0);
      end
      pix_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({pix_valid, pix_last, pix_data} !== {1'b1, 1'b1, exp_pix(24'h141516)}) begin
         failures++;
         $display("[TB] FAIL bp_back_to_back: got valid=%b last=%b data=%h, expected 1 1 %h",
                  pix_valid, pix_last, pix_data, exp_pix(24'h141516));
      end
      @(negedge clk);
      checks++;
      if ({frame_done, busy, pix_valid} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL bp_frame_end: got done,busy,valid=%b%b%b, expected 100", frame_done, busy, pix_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_stall();
      int a0, p0, f0, s0, g0;
      s0 = stall_hi_cycles;
      g0 = addr_glitch;
      stall_addr = 8'h11;
      stall_len = 7;
      run_frame(8'h10, -1, a0, p0, f0);
      @(negedge clk);
      stall_len = 0;
      checks++;
      if (stall_hi_cycles - s0 !== 9) begin
         failures++;
         $display("[TB] FAIL stall_req_held: got %0d cycles, expected 9", stall_hi_cycles - s0);
      end
      checks++;
      if (addr_glitch - g0 !== 0) begin
         failures++;
         $display("[TB] FAIL stall_addr_stable: got %0d changes, expected 0", addr_glitch - g0);
      end
      checks++;
      if (addr_log.size() - a0 !== 6) begin
         failures++;
         $display("[TB] FAIL stall_no_dup_req: got %0d requests, expected 6", addr_log.size() - a0);
      end
      checks++;
      if ({pix_log[p0], pix_log[p0+1]} !== {exp_pix(24'h010203), exp_pix(24'h040506)}) begin
         failures++;
         $display("[TB] FAIL stall_data: got %h %h, expected %h %h", pix_log[p0], pix_log[p0+1],
                  exp_pix(24'h010203), exp_pix(24'h040506));
      end
   endtask

   task automatic test_wrap();
      int a0, p0, f0;
      logic [AW-1:0] exp_addr [6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
      run_frame(8'hFE, -1, a0, p0, f0);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (addr_log[a0+i] !== exp_addr[i]) begin
            failures++;
            $display("[TB] FAIL wrap_addr[%0d]: got %h, expected %h", i, addr_log[a0+i], exp_addr[i]);
         end
      end
      checks++;
      if ({pix_log[p0], pix_log[p0+1]} !== {exp_pix(24'hEFF0F1), exp_pix(24'hF2F3F4)}) begin
         failures++;
         $display("[TB] FAIL wrap_data: got %h %h, expected %h %h", pix_log[p0], pix_log[p0+1],
                  exp_pix(24'hEFF0F1), exp_pix(24'hF2F3F4));
      end
   endtask

   task automatic test_start_while_busy();
      int a0, p0, f0;
      run_frame(8'h10, 6, a0, p0, f0);
      @(negedge clk);
      checks++;
      if (addr_log.size() - a0 !== 6) begin
         failures++;
         $display("[TB] FAIL busy_start_req_count: got %0d, expected 6", addr_log.size() - a0);
      end
      checks++;
      if ({addr_log[a0+1], addr_log[a0+2], addr_log[a0+5]} !== {8'h11, 8'h12, 8'h15}) begin
         failures++;
         $display("[TB] FAIL busy_start_addr: got %h %h %h, expected 11 12 15",
                  addr_log[a0+1], addr_log[a0+2], addr_log[a0+5]);
      end
      checks++;
      if (done_count - f0 !== 1) begin
         failures++;
         $display("[TB] FAIL busy_start_done_count: got %0d, expected 1", done_count - f0);
      end
   endtask

   task automatic test_mid_frame_reset();
      int a0, p0, f0, d0;
      d0 = done_count;
      @(negedge clk);
      start = 1'b1;
      base_addr = 8'h10;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, frame_done, data_req, pix_valid, pix_last, data_addr, pix_data} !== '0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: got busy=%b done=%b req=%b valid=%b addr=%h data=%h, expected all 0",
                  busy, frame_done, data_req, pix_valid, data_addr, pix_data);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      checks++;
      if (done_count - d0 !== 0) begin
         failures++;
         $display("[TB] FAIL midreset_no_done: got %0d pulses, expected 0", done_count - d0);
      end
      checks++;
      if ({busy, data_req} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL midreset_idle: got busy=%b req=%b, expected 0 0", busy, data_req);
      end
      run_frame(8'h30, -1, a0, p0, f0);
      @(negedge clk);
      checks++;
      if ({pix_log[p0], pix_log[p0+1]} !== {exp_pix(24'h212223), exp_pix(24'h242526)}) begin
         failures++;
         $display("[TB] FAIL midreset_clean_frame: got %h %h, expected %h %h", pix_log[p0], pix_log[p0+1],
                  exp_pix(24'h212223), exp_pix(24'h242526));
      end
      checks++;
      if (addr_log[a0] !== 8'h30) begin
         failures++;
         $display("[TB] FAIL midreset_first_addr: got %h, expected 30", addr_log[a0]);
      end
   endtask

   task automatic test_brightness();
      int a0, p0, f0;
      logic [WW-1:0] exp0, exp1, expz0, expz1;
`ifdef LED_PIXEL_FETCHER_BRIGHTNESS_EN
      exp0 = 24'h7F0000;
      exp1 = 24'h010102;
      expz0 = 24'h000000;
      expz1 = 24'h000000;
`else
      exp0 = 24'hFF0001;
      exp1 = 24'h020304;
      expz0 = 24'hFF0001;
      expz1 = 24'h020304;
`endif
      brightness = 8'd128;
      run_frame(8'h0E, -1, a0, p0, f0);
      @(negedge clk);
      checks++;
      if ({pix_log[p0], pix_log[p0+1]} !== {exp0, exp1}) begin
         failures++;
         $display("[TB] FAIL bright_128: got %h %h, expected %h %h", pix_log[p0], pix_log[p0+1], exp0, exp1);
      end
      brightness = 8'd0;
      run_frame(8'h0E, -1, a0, p0, f0);
      @(negedge clk);
      checks++;
      if ({pix_log[p0], pix_log[p0+1]} !== {expz0, expz1}) begin
         failures++;
         $display("[TB] FAIL bright_0: got %h %h, expected %h %h", pix_log[p0], pix_log[p0+1], expz0, expz1);
      end
      brightness = 8'hFF;
   endtask

   // Runs every scenario in order, then prints the summary.
   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_stall();
      test_wrap();
      test_start_while_busy();
      test_mid_frame_reset();
      test_brightness();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
